fv_mc_fifo: RTL and testbench
=============================

# fv_mc_fifo

Multi-channel formal reference FIFO model: `NumChannels` independent FIFOs, each `Depth` entries of `DataWidth` bits, with an optional same-cycle bypass mode. Each channel also exposes an occupancy count and an almost-full flag. It serves as the golden scoreboard in FPV testbenches for multi-flow blocks such as arbiters, multi-FIFOs and VC buffers. Property modules compare DUT pop data and flags against it channel by channel.

## Interface
- `NumChannels`, default 2: number of independent channels, ≥1.
- `Depth`, default 4: entries per channel, ≥1, need not be a power of 2.
- `DataWidth`, default 4: payload bits, ≥1.
- `Bypass`, default 0: when 1, a push to an empty channel is poppable in the same cycle.
- `AlmostFullThreshold`, default `Depth`-1: `almost_full` asserts when count ≥ this value; range 1..`Depth`.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `push` in `NumChannels`: per-channel push strobe.
- `push_data` in `NumChannels`×`DataWidth`: per-channel write data.
- `pop` in `NumChannels`: per-channel pop strobe.
- `pop_data` out `NumChannels`×`DataWidth`: head entry of each channel (combinational).
- `empty` out `NumChannels`: count == 0.
- `full` out `NumChannels`: count == `Depth`.
- `almost_full` out `NumChannels`: count ≥ `AlmostFullThreshold`.
- `count` out `NumChannels`×`CountWidth`: occupancy, where `CountWidth` = $clog2(`Depth`+1).

## Operation
- Channels are fully independent and share no state.
- Pointer width is max(1, $clog2(`Depth`)). A pointer wraps from `Depth`-1 to 0, which is explicit for non-power-of-2 `Depth`.
- Non-bypass mode:
  - A push writes `mem[wr_ptr]` and advances `wr_ptr`.
  - A pop advances `rd_ptr`.
  - `pop_data` = `mem[rd_ptr]`.
- Bypass mode, channel empty, push and pop in the same cycle:
  - The data passes through as `pop_data` = `push_data`.
  - Neither pointer moves, count is unchanged, and memory is not written.
- Bypass mode, channel empty, otherwise: `pop_data` = `push_data`, which is don't-care unless a pop occurs.
- Bypass mode, channel non-empty: behaves exactly like non-bypass mode.
- `count` next value = count + push − pop, computed in `CountWidth`+1 bits with no wrap.
- Legal-use rules:
  - Non-bypass: no push when full; no pop when empty.
  - Bypass: push when full is legal only with a same-cycle pop; pop when empty is legal only with a same-cycle push.
  - Non-bypass: push and pop at full is illegal, even though a pop occurs in the same cycle.
- Illegal-use handling: see Configuration.

## Timing
- Reset values:
  - `empty` = all 1.
  - `full` = 0.
  - `count` = 0.
  - `almost_full` = 0.
  - Pointers = 0 and all memory entries = 0, so `pop_data` = 0 in non-bypass mode.
  - In bypass mode `pop_data` = `push_data` during and immediately after reset.
- Asserting `rst` mid-operation clears all channels immediately; no in-flight data survives.
- Push-to-pop latency:
  - Non-bypass: 1 cycle. Data pushed at edge N appears on `pop_data` after edge N if it is the head.
  - Bypass: 0 cycles into an empty channel.
- `count`, `empty`, `full` and `almost_full` update one cycle after the push or pop.

## Configuration
- Macro: `FV_MC_FIFO_CHECKS_EN`.
- Defined:
  - Per-channel `BR_ASSERT`s `no_push_full_a` and `no_pop_empty_a` encode the legal-use rules.
  - `count` ≤ `Depth` is asserted.
  - Illegal stimulus is a property failure.
- Undefined:
  - No assertions are emitted.
  - An illegal push is dropped: no write, no pointer move, count unchanged.
  - An illegal pop is ignored: no pointer move, count unchanged.
  - The model therefore stays self-consistent when driven unconstrained, for use as an assumption-free monitor.

## Structure
- Package `fv_mc_fifo_pkg`:
  - `ptr_width(depth)` and `count_width(depth)` functions.
  - `next_ptr(ptr, depth)` wrap function.
- Sub-module `fv_mc_fifo_channel`:
  - Holds one channel's memory, pointers, counter and flags.
  - Takes `Depth`, `DataWidth`, `Bypass` and `AlmostFullThreshold`.
  - The top level instantiates it `NumChannels` times in a generate loop and wires the packed port slices.

## Test plan
- Default parameters, push 0xA, 0xB, 0xC on ch0, then pop three times → `pop_data` reads 0xA, 0xB, 0xC; `count` goes 1,2,3,2,1,0; ch1 stays `empty`=1, `count`=0.
- `Depth`=3 (non-power-of-2), 10 push+pop cycles in steady state at count 1 → pointers wrap 2→0; data stays in order; `count` stays 1.
- `Depth`=4, fill ch1 → `almost_full`=1 at count 3, `full`=1 at count 4.
  - Checks on: a push at full fails `no_push_full_a`.
  - Checks off: the data is dropped and `count` stays 4.
- `Bypass`=1, ch0 empty, push 0x5 with pop in the same cycle → `pop_data`=0x5 that cycle; next cycle `empty`=1 and `count`=0.
- Push 0x7 to ch0, assert `rst` mid-stream for 1 cycle → all `empty`=1, `count`=0, `pop_data`=0 (non-bypass).
- `NumChannels`=4, simultaneous pushes of distinct data to all channels plus a pop on ch2 only → ch2 `count` unchanged; the others increment; no cross-channel data leakage.

Source files
------------

// File: rtl/fv_mc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fv_mc_fifo_pkg
// Purpose  : Shared sizing and pointer helpers for the multi-channel
//            reference FIFO (fv_mc_fifo and its channel sub-module).
// Contents : ptr_width(depth)      - pointer width, never below 1 bit
//            count_width(depth)    - occupancy width, holds 0..depth
//            next_ptr(ptr, depth)  - explicit wrap at depth-1, so depths
//                                    that are not a power of 2 work
// Revision : 1.0 - initial release
// ============================================================================
package fv_mc_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int next_ptr(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fv_mc_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : fv_mc_fifo_if
// Purpose  : Bundles the per-channel push/pop handshake and status vectors
//            of fv_mc_fifo. Every signal is packed per channel.
// Ports    : push, push_data, pop       - driven by the master
//            pop_data, empty, full,
//            almost_full, count          - driven by the FIFO (slave)
// Modports : master (stimulus side), slave (FIFO side)
// Revision : 1.0 - initial release
// ============================================================================
interface fv_mc_fifo_if
    import fv_mc_fifo_pkg::*;
#(
    parameter int NumChannels = 2,
    parameter int Depth       = 4,
    parameter int DataWidth   = 4
);
    localparam int CountWidth = count_width(Depth);

    logic [NumChannels-1:0]                 push;
    logic [NumChannels-1:0][DataWidth-1:0]  push_data;
    logic [NumChannels-1:0]                 pop;
    logic [NumChannels-1:0][DataWidth-1:0]  pop_data;
    logic [NumChannels-1:0]                 empty;
    logic [NumChannels-1:0]                 full;
    logic [NumChannels-1:0]                 almost_full;
    logic [NumChannels-1:0][CountWidth-1:0] count;

    modport master (
        output push, push_data, pop,
        input  pop_data, empty, full, almost_full, count
    );

    modport slave (
        input  push, push_data, pop,
        output pop_data, empty, full, almost_full, count
    );
endinterface
`default_nettype wire

// File: rtl/fv_mc_fifo_channel.sv
`default_nettype none
// ============================================================================
// Module   : fv_mc_fifo_channel
// Purpose  : One channel of the reference FIFO: storage, read/write
//            pointers, occupancy counter and status flags.
// Ports    : clk, rst (async, active-high)
//            push / push_data / pop   - channel handshake
//            pop_data                 - head entry (combinational)
//            empty, full, almost_full - derived from the registered count
//            count                    - occupancy
// Macro    : FV_MC_FIFO_CHECKS_EN enables the legal-use assertions.
// Revision : 1.0 - initial release
// ============================================================================
module fv_mc_fifo_channel
    import fv_mc_fifo_pkg::*;
#(
    parameter int Depth               = 4,
    parameter int DataWidth           = 4,
    parameter int Bypass              = 0,
    parameter int AlmostFullThreshold = (Depth > 1) ? Depth - 1 : 1
) (
    input  wire logic                                clk,
    input  wire logic                                rst,
    input  wire logic                                push,
    input  wire logic [DataWidth-1:0]                push_data,
    input  wire logic                                pop,
    output logic      [DataWidth-1:0]                pop_data,
    output logic                                     empty,
    output logic                                     full,
    output logic                                     almost_full,
    output logic      [count_width(Depth)-1:0]       count
);
    localparam int PTR_W = ptr_width(Depth);
    localparam int CNT_W = count_width(Depth);

    localparam logic [CNT_W-1:0] c_depth   = CNT_W'(Depth);
    localparam logic [CNT_W-1:0] c_af_thr  = CNT_W'(AlmostFullThreshold);
    localparam bit               c_bypass  = (Bypass != 0);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pass_thru;
    logic                 w_wr_en;
    logic                 w_rd_en;
    logic [CNT_W:0]       w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // Bypass into an empty channel: the word is consumed combinationally and
    // never touches storage, pointers or the counter.
    assign w_pass_thru = c_bypass && w_empty && push && pop;

    // Illegal pushes/pops are dropped so the model stays self-consistent when
    // driven unconstrained. In bypass mode a push at full is accepted when a
    // pop frees the head slot in the same cycle.
    assign w_wr_en = push && !w_pass_thru && (!w_full || (c_bypass && pop));
    assign w_rd_en = pop && !w_empty;

    assign w_count_nxt = {1'b0, r_count} + (CNT_W+1)'(w_wr_en) - (CNT_W+1)'(w_rd_en);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= PTR_W'(next_ptr(int'(r_wr_ptr), Depth));
            end
            if (w_rd_en) begin
                r_rd_ptr <= PTR_W'(next_ptr(int'(r_rd_ptr), Depth));
            end
            // The extra count bit can only be set by an overflow the gating
            // above already prevents; clamp instead of wrapping regardless.
            r_count <= w_count_nxt[CNT_W] ? c_depth : w_count_nxt[CNT_W-1:0];
        end
    end

    assign pop_data    = (c_bypass && w_empty) ? push_data : r_mem[r_rd_ptr];
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= c_af_thr);
    assign count       = r_count;

`ifdef FV_MC_FIFO_CHECKS_EN
    no_push_full_a: assert property (@(posedge clk) disable iff (rst)
        !(push && w_full && !(c_bypass && pop)));

    no_pop_empty_a: assert property (@(posedge clk) disable iff (rst)
        !(pop && w_empty && !(c_bypass && push)));

    count_le_depth_a: assert property (@(posedge clk) disable iff (rst)
        r_count <= c_depth);
`else
    // Unchecked build: illegal stimulus is silently dropped by the gating.
`endif

endmodule
`default_nettype wire

// File: rtl/fv_mc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fv_mc_fifo
// Purpose  : Multi-channel reference FIFO. NumChannels fully independent
//            channels of Depth x DataWidth, optional same-cycle bypass into
//            an empty channel, per-channel count and almost-full flag.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous, active-high reset
//            bus  - fv_mc_fifo_if.slave (push/push_data/pop in,
//                   pop_data/empty/full/almost_full/count out)
// Macro    : FV_MC_FIFO_CHECKS_EN - when defined, per-channel legal-use
//            assertions; when undefined, illegal stimulus is dropped.
// Revision : 1.0 - initial release
// ============================================================================
module fv_mc_fifo
    import fv_mc_fifo_pkg::*;
#(
    parameter int NumChannels         = 2,
    parameter int Depth               = 4,
    parameter int DataWidth           = 4,
    parameter int Bypass              = 0,
    parameter int AlmostFullThreshold = (Depth > 1) ? Depth - 1 : 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fv_mc_fifo_if.slave  bus
);

    for (genvar g = 0; g < NumChannels; g++) begin : g_ch
        fv_mc_fifo_channel #(
            .Depth               (Depth),
            .DataWidth           (DataWidth),
            .Bypass              (Bypass),
            .AlmostFullThreshold (AlmostFullThreshold)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .push        (bus.push[g]),
            .push_data   (bus.push_data[g]),
            .pop         (bus.pop[g]),
            .pop_data    (bus.pop_data[g]),
            .empty       (bus.empty[g]),
            .full        (bus.full[g]),
            .almost_full (bus.almost_full[g]),
            .count       (bus.count[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_fv_mc_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fv_mc_fifo
// Purpose  : Self-checking bench for fv_mc_fifo. Two instances:
//            dut0 - 2 channels, depth 4, 4-bit data, no bypass
//            dut1 - 4 channels, depth 3, 8-bit data, bypass
//            A queue-per-channel model is compared against every output on
//            each falling edge; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fv_mc_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fv_mc_fifo_if #(.NumChannels(2), .Depth(4), .DataWidth(4)) if0 ();
    fv_mc_fifo_if #(.NumChannels(4), .Depth(3), .DataWidth(8)) if1 ();

    fv_mc_fifo #(.NumChannels(2), .Depth(4), .DataWidth(4), .Bypass(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    fv_mc_fifo #(.NumChannels(4), .Depth(3), .DataWidth(8), .Bypass(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [7:0] m0 [2][$];
    logic [7:0] m1 [4][$];

    task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, ch, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue per channel, updated by the FIFO rules.
    int  sz;
    bit  pu, po;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) m0[c].delete();
            for (int c = 0; c < 4; c++) m1[c].delete();
        end else begin
            for (int c = 0; c < 2; c++) begin
                sz = m0[c].size();
                pu = if0.push[c];
                po = if0.pop[c];
                if (po && sz > 0) void'(m0[c].pop_front());
                if (pu && sz < 4) m0[c].push_back(8'(if0.push_data[c]));
            end
            for (int c = 0; c < 4; c++) begin
                sz = m1[c].size();
                pu = if1.push[c];
                po = if1.pop[c];
                if (!(sz == 0 && pu && po)) begin
                    if (po && sz > 0) void'(m1[c].pop_front());
                    if (pu && (sz < 3 || po)) m1[c].push_back(if1.push_data[c]);
                end
            end
        end
    end

    // Compare process: every output of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int c = 0; c < 2; c++) begin
                chk("d0_empty", c, 32'(if0.empty[c]),       32'(m0[c].size() == 0));
                chk("d0_full",  c, 32'(if0.full[c]),        32'(m0[c].size() == 4));
                chk("d0_afull", c, 32'(if0.almost_full[c]), 32'(m0[c].size() >= 3));
                chk("d0_count", c, 32'(if0.count[c]),       32'(m0[c].size()));
                if (m0[c].size() > 0)
                    chk("d0_data", c, 32'(if0.pop_data[c]), 32'(m0[c][0][3:0]));
            end
            for (int c = 0; c < 4; c++) begin
                chk("d1_empty", c, 32'(if1.empty[c]),       32'(m1[c].size() == 0));
                chk("d1_full",  c, 32'(if1.full[c]),        32'(m1[c].size() == 3));
                chk("d1_afull", c, 32'(if1.almost_full[c]), 32'(m1[c].size() >= 2));
                chk("d1_count", c, 32'(if1.count[c]),       32'(m1[c].size()));
                if (m1[c].size() > 0)
                    chk("d1_data", c, 32'(if1.pop_data[c]), 32'(m1[c][0]));
                else
                    chk("d1_bypass", c, 32'(if1.pop_data[c]), 32'(if1.push_data[c]));
            end
        end
    end

    int pr;

    initial begin
        rst           = 1'b1;
        if0.push      = '0;
        if0.pop       = '0;
        if0.push_data = '0;
        if1.push      = '0;
        if1.pop       = '0;
        if1.push_data = 32'hA5C3_1E0F;
        cmp_en        = 1'b1;
        repeat (2) tick();

        // Reset state
        chk("rst_empty0", 0, 32'(if0.empty),       32'h3);
        chk("rst_full0",  0, 32'(if0.full),        32'h0);
        chk("rst_afull0", 0, 32'(if0.almost_full), 32'h0);
        chk("rst_count0", 0, 32'(if0.count),       32'h0);
        chk("rst_data0",  0, 32'(if0.pop_data),    32'h0);
        chk("rst_empty1", 1, 32'(if1.empty),       32'hF);
        chk("rst_data1",  1, 32'(if1.pop_data),    32'hA5C3_1E0F);
        rst = 1'b0;
        if1.push_data = '0;

        // dut0 ch0: push A, B, C then pop three times
        if0.push = 2'b01;
        if0.push_data[0] = 4'hA; tick();
        chk("seq_cnt", 0, 32'(if0.count[0]), 1);
        chk("seq_head", 0, 32'(if0.pop_data[0]), 32'hA);
        if0.push_data[0] = 4'hB; tick();
        chk("seq_cnt", 0, 32'(if0.count[0]), 2);
        if0.push_data[0] = 4'hC; tick();
        chk("seq_cnt", 0, 32'(if0.count[0]), 3);
        chk("seq_afull", 0, 32'(if0.almost_full[0]), 1);
        chk("seq_full", 0, 32'(if0.full[0]), 0);
        if0.push = 2'b00;
        if0.pop  = 2'b01;
        chk("seq_pop", 0, 32'(if0.pop_data[0]), 32'hA);
        tick();
        chk("seq_cnt", 0, 32'(if0.count[0]), 2);
        chk("seq_pop", 0, 32'(if0.pop_data[0]), 32'hB);
        tick();
        chk("seq_cnt", 0, 32'(if0.count[0]), 1);
        chk("seq_pop", 0, 32'(if0.pop_data[0]), 32'hC);
        tick();
        chk("seq_cnt", 0, 32'(if0.count[0]), 0);
        chk("seq_empty", 0, 32'(if0.empty[0]), 1);
        chk("iso_empty", 1, 32'(if0.empty[1]), 1);
        chk("iso_cnt", 1, 32'(if0.count[1]), 0);
        if0.pop = 2'b00;

        // dut0 ch1: fill to full, push at full is dropped
        if0.push = 2'b10;
        for (int v = 1; v <= 4; v++) begin
            if0.push_data[1] = 4'(v);
            tick();
            chk("fill_cnt", 1, 32'(if0.count[1]), 32'(v));
            chk("fill_afull", 1, 32'(if0.almost_full[1]), 32'(v >= 3));
            chk("fill_full", 1, 32'(if0.full[1]), 32'(v == 4));
        end
        if0.push_data[1] = 4'h9;
        tick();
        chk("drop_cnt", 1, 32'(if0.count[1]), 4);
        chk("drop_head", 1, 32'(if0.pop_data[1]), 1);
        if0.push = 2'b00;
        if0.pop  = 2'b10;
        for (int v = 1; v <= 4; v++) begin
            chk("drain", 1, 32'(if0.pop_data[1]), 32'(v));
            tick();
        end
        if0.pop = 2'b00;
        chk("drain_empty", 1, 32'(if0.empty[1]), 1);

        // Reset mid-stream
        if0.push = 2'b01;
        if0.push_data[0] = 4'h7;
        tick();
        chk("mid_cnt", 0, 32'(if0.count[0]), 1);
        if0.push = 2'b00;
        rst = 1'b1;
        #1;
        chk("mid_rst_empty", 0, 32'(if0.empty), 32'h3);
        chk("mid_rst_cnt", 0, 32'(if0.count), 0);
        chk("mid_rst_data", 0, 32'(if0.pop_data), 0);
        tick();
        rst = 1'b0;

        // dut1 ch0: bypass into empty channel
        if1.push = 4'b0001;
        if1.pop  = 4'b0001;
        if1.push_data[0] = 8'h05;
        #1;
        chk("byp_data", 0, 32'(if1.pop_data[0]), 32'h05);
        tick();
        if1.push = '0;
        if1.pop  = '0;
        chk("byp_empty", 0, 32'(if1.empty[0]), 1);
        chk("byp_cnt", 0, 32'(if1.count[0]), 0);

        // dut1 ch1: depth-3 wrap in steady state at count 1
        if1.push = 4'b0010;
        if1.push_data[1] = 8'h10;
        tick();
        if1.pop = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            if1.push_data[1] = 8'(8'h11 + i);
            #1;
            chk("wrap_data", 1, 32'(if1.pop_data[1]), 32'(8'h10 + i));
            tick();
            chk("wrap_cnt", 1, 32'(if1.count[1]), 1);
        end
        if1.push = '0;
        if1.pop  = '0;

        // dut1: preload ch2, then push all four with a pop on ch2 only
        if1.push = 4'b0100;
        if1.push_data[2] = 8'h22;
        tick();
        if1.push = 4'b1111;
        if1.pop  = 4'b0100;
        for (int c = 0; c < 4; c++) if1.push_data[c] = 8'(8'h40 + c);
        tick();
        if1.push = '0;
        if1.pop  = '0;
        chk("all_cnt", 0, 32'(if1.count[0]), 1);
        chk("all_cnt", 1, 32'(if1.count[1]), 2);
        chk("all_cnt", 2, 32'(if1.count[2]), 1);
        chk("all_cnt", 3, 32'(if1.count[3]), 1);
        chk("all_data", 0, 32'(if1.pop_data[0]), 32'h40);
        chk("all_data", 1, 32'(if1.pop_data[1]), 32'h1A);
        chk("all_data", 2, 32'(if1.pop_data[2]), 32'h42);
        chk("all_data", 3, 32'(if1.pop_data[3]), 32'h43);

        // Random phase: unconstrained stimulus, alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            pr = ((i / 150) % 2 == 0) ? 75 : 30;
            for (int c = 0; c < 2; c++) begin
                if0.push[c] = ($urandom_range(0, 99) < pr);
                if0.pop[c]  = ($urandom_range(0, 99) < 100 - pr);
            end
            for (int c = 0; c < 4; c++) begin
                if1.push[c] = ($urandom_range(0, 99) < pr);
                if1.pop[c]  = ($urandom_range(0, 99) < 100 - pr);
            end
            if0.push_data = 8'($urandom);
            if1.push_data = 32'($urandom);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
